// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit path and the frame generator.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic parity_en(parity_t p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity rule shared by the transmit sequencer and the frame generator.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  parity_t           parity_type,
    output logic              parity_bit,
    output logic              par_en
);

    always_comb begin
        parity_bit = (parity_type == PAR_ODD) ? ~^data : ^data;
        par_en     = parity_en(parity_type);
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte over valid/ready and serialises one frame onto tx.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        parity_type,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    if (CLKS_PER_BIT < 2) begin : g_param_check
        $error("CLKS_PER_BIT must be >= 2");
    end

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] data_q;
    parity_t           par_q;
    logic              tx_q, tx_d;
    logic              parity_bit;
    logic              par_en;
    logic              accept;

    uart_parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity (
        .data        (data_q),
        .parity_type (par_q),
        .parity_bit  (parity_bit),
        .par_en      (par_en)
    );

    assign accept = tx_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            bit_d = '0;
            if (tx_valid) begin
                state_d = START;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    if (bit_q == BIT_LAST) begin
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // tx is registered, so it is derived from the state about to be entered.
    always_comb begin
        tx_d = STOP_BIT;
        unique case (state_d)
            IDLE:    tx_d = STOP_BIT;
            START:   tx_d = START_BIT;
            DATA:    tx_d = data_q[bit_d];
            PARITY:  tx_d = parity_bit;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= STOP_BIT;
            data_q  <= '0;
            par_q   <= PAR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            if (accept) begin
                data_q <= tx_data;
                par_q  <= parity_t'(parity_type);
            end
        end
    end

    always_comb begin
        tx       = tx_q;
        tx_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        done     = (state_q == STOP) && (cnt_q == CNT_LAST);
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed scoreboard bench for uart_tx_ctrl with CLKS_PER_BIT=4.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic [1:0] parity_type;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       done;

    bit exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .parity_type (parity_type),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line bits of one frame, computed from the byte and parity mode.
    task automatic push_frame(input logic [7:0] d, input logic [1:0] p);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (p == 2'b01) exp_q.push_back(^d);
        else if (p == 2'b10) exp_q.push_back(~^d);
        exp_q.push_back(1'b1);
    endtask

    // Starts at a negedge; returns at the negedge of the first cycle after accept.
    task automatic request(input logic [7:0] d, input logic [1:0] p, input bit hold);
        bit ok = 0;
        tx_data     = d;
        parity_type = p;
        tx_valid    = 1'b1;
        push_frame(d, p);
        for (int i = 0; i < 100; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Walks one frame from cycle 1 after accept; ends at the negedge of the idle cycle.
    task automatic check_frame(input string tag, input int nbits, input int chg_at,
                               input logic [7:0] nd, input logic [1:0] np);
        int len = nbits * CPB;
        int busy_n = 0;
        int done_n = 0;
        int done_at = 0;
        int comp_bad = 0;
        for (int k = 1; k <= len; k++) begin
            if (busy) busy_n++;
            if (busy === tx_ready) comp_bad++;
            if (done) begin
                done_n++;
                done_at = k;
            end
            if (k == chg_at) begin
                tx_data     = nd;
                parity_type = np;
                push_frame(nd, np);
            end
            if ((k - 1) % CPB == CPB / 2) begin
                if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
                else check({tag, "_bit"}, 32'(tx), 32'(exp_q.pop_front()));
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(len));
        check({tag, "_done_count"}, 32'(done_n), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_at), 32'(len));
        check({tag, "_complement"}, 32'(comp_bad), 32'd0);
        check({tag, "_idle_tx"}, 32'(tx), 32'd1);
        check({tag, "_idle_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        parity_type = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // 1: even parity
        request(8'hA5, 2'b01, 0);
        check_frame("t1", 11, 0, 8'h00, 2'b00);

        // 2: odd parity
        request(8'h01, 2'b10, 0);
        check_frame("t2", 11, 0, 8'h00, 2'b00);

        // 3: no parity, both encodings
        request(8'hFF, 2'b00, 0);
        check_frame("t3a", 10, 0, 8'h00, 2'b00);
        request(8'hFF, 2'b11, 0);
        check_frame("t3b", 10, 0, 8'h00, 2'b00);

        // 4: back-to-back with tx_valid held high
        request(8'h3C, 2'b01, 1);
        check_frame("t4a", 11, 20, 8'hC3, 2'b01);
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame("t4b", 11, 0, 8'h00, 2'b00);

        // 5: inputs changed mid-frame are ignored until the next accept
        request(8'h55, 2'b01, 1);
        check_frame("t5a", 11, 22, 8'h00, 2'b00);
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame("t5b", 10, 0, 8'h00, 2'b00);

        // 6: reset during data bit 3 abandons the frame
        request(8'hF0, 2'b00, 0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_tx", 32'(tx), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ready", 32'(tx_ready), 32'd1);
        check("t6_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        request(8'h81, 2'b10, 0);
        check_frame("t6", 11, 0, 8'h00, 2'b00);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side sequencer for the UART. It accepts a byte and a parity mode over a valid/ready handshake, latches both, and serialises one frame onto the line. The frame is a start bit, 8 data bits LSB first, an optional parity bit, and a stop bit. Bit timing comes from an internal per-bit cycle counter. The block sits between the host-side byte source and the tx pin, and uses the same parity_type encoding as the frame generator.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2 (elaboration assertion).
DATA_W, 8, data bits per frame.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; synchronous, active-high.
tx_data  input  DATA_W  byte to send; sampled on accept.
parity_type  input  2  00 none, 01 even, 10 odd, 11 none; sampled on accept.
tx_valid  input  1  requester has a byte.
tx_ready  output  1  controller can accept; high only in IDLE.
tx  output  1  serial line, registered, idles high.
busy  output  1  high from the first start-bit cycle to the last stop-bit cycle inclusive.
done  output  1  one-cycle pulse on the last stop-bit cycle.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, tx=1, busy=0, done=0, tx_ready=1, bit and cycle counters cleared. This applies mid-frame too; the frame is abandoned and nothing is resumed.
- Accept: the edge where tx_valid && tx_ready. At that edge tx_data and parity_type are latched into shadow registers, and the parity bit is computed from the latched data.
  - Even: ^data.
  - Odd: ~^data.
- Inputs changing after accept have no effect. tx_valid while busy is ignored.
- Cycle timing: accept at edge T; tx=0, busy=1, tx_ready=0 from T+1.
- FSM states and transitions:
  - IDLE: tx=1, tx_ready=1. Goes to START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=data[bit_idx], bit_idx 0..DATA_W-1, CLKS_PER_BIT cycles per bit. After bit DATA_W-1, go to PARITY if parity_type is 01 or 10, else STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. done=1 on its final cycle, then IDLE.
- Frame lengths: 11*CLKS_PER_BIT cycles with parity, 10*CLKS_PER_BIT without.
- Cycle counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. bit_idx only advances on a wrap.
- Back-to-back frames: after done, IDLE lasts at least 1 cycle with tx=1. If tx_valid is already high in that cycle, accept happens there and the next start bit begins on the following cycle.
- busy and tx_ready are exact complements outside reset.
- No combinational path from tx_valid to tx_ready.

Decomposition:
- Package uart_pkg:
  - parity_t enum: PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10, PAR_NONE2=2'b11.
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - Function parity_en(parity_t).
  - Constants START_BIT=0 and STOP_BIT=1.
- Sub-module uart_parity_calc: combinational; inputs data and parity_type; outputs parity bit and parity_en. It is shared with the frame generator's parity rule.

Test Plan (CLKS_PER_BIT=4):
1. tx_data=8'hA5, parity_type=01 -> tx bits sampled mid-bit are 0,1,0,1,0,0,1,0,1,0,1. busy high for 44 cycles; done on cycle 44 after accept.
2. tx_data=8'h01, parity_type=10 -> parity bit 0; bits 0,1,0,0,0,0,0,0,0,0,1; 44 cycles.
3. tx_data=8'hFF with parity_type=00, then repeated with 11 -> bits 0,1,1,1,1,1,1,1,1,1; no parity slot; done at cycle 40 in both cases.
4. tx_valid held high with 8'h3C then 8'hC3 (even) -> exactly one idle cycle (tx=1, tx_ready=1) between done and the second start bit. The second frame carries 8'hC3 and parity 0.
5. tx_data and parity_type changed to 8'h00/00 in mid-frame of 8'h55/01, with tx_valid high throughout -> frame bits unchanged and parity still sent. The new request is accepted only in IDLE after done.
6. rst=1 for one edge during data bit 3 -> the next cycle shows tx=1, busy=0, tx_ready=1, done=0. A new 8'h81/10 frame then transmits correctly from a clean start bit.
